// File: rtl/systola_pkg.sv
// systola_pkg: shared constants and types for the linear PE array and its sequencer.
//   LANES / DW / ACCW : lane count, operand width, accumulator width
//   seq_state_t       : sequencer FSM states
//   op_vec_t          : one operand (weight or activation) per lane
//   res_vec_t         : one accumulator result per lane
package systola_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned ACCW  = 12;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StResult
    } seq_state_t;

    typedef logic [LANES-1:0][DW-1:0]   op_vec_t;
    typedef logic [LANES-1:0][ACCW-1:0] res_vec_t;

endpackage

// File: rtl/pe_lin_seq_if.sv
// pe_lin_seq_if: all handshake and data signals around the PE-array sequencer.
//   Job request  : start_valid / start_ready, k_len, abort
//   Operand feed : in_valid / in_ready, in_w, in_a
//   Array side   : pe_clr, pe_fire, pe_w, pe_a (to array), pe_outs (from array)
//   Result       : res_valid / res_ready, res
// Modports: slave = the sequencer, master = its environment (buffer, array, consumer).
interface pe_lin_seq_if #(
    parameter int unsigned LANES = systola_pkg::LANES,
    parameter int unsigned DW    = systola_pkg::DW,
    parameter int unsigned ACCW  = systola_pkg::ACCW,
    parameter int unsigned KW    = 8
);

    logic                        start_valid;
    logic                        start_ready;
    logic [KW-1:0]               k_len;
    logic                        abort;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES-1:0][DW-1:0]    in_w;
    logic [LANES-1:0][DW-1:0]    in_a;
    logic                        pe_clr;
    logic [LANES-1:0]            pe_fire;
    logic [LANES-1:0][DW-1:0]    pe_w;
    logic [LANES-1:0][DW-1:0]    pe_a;
    logic [LANES-1:0][ACCW-1:0]  pe_outs;
    logic                        res_valid;
    logic                        res_ready;
    logic [LANES-1:0][ACCW-1:0]  res;

    modport master (
        output start_valid, k_len, abort, in_valid, in_w, in_a, pe_outs, res_ready,
        input  start_ready, in_ready, pe_clr, pe_fire, pe_w, pe_a, res_valid, res
    );

    modport slave (
        input  start_valid, k_len, abort, in_valid, in_w, in_a, pe_outs, res_ready,
        output start_ready, in_ready, pe_clr, pe_fire, pe_w, pe_a, res_valid, res
    );

endinterface

// File: rtl/skew_line.sv
// skew_line: fixed-depth delay line carrying {fire, data} for one PE lane.
//   clk, rstn  : clock, asynchronous active-low clear
//   flush      : synchronous clear of every stage (used on job abort)
//   push_fire  : fire bit entering stage 0
//   push_data  : payload entering stage 0
//   fire, data : outputs of the last stage, D cycles after entry
module skew_line #(
    parameter int unsigned D = 1,
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push_fire,
    input  logic [W-1:0] push_data,
    output logic         fire,
    output logic [W-1:0] data
);

    logic         fire_q [D];
    logic [W-1:0] data_q [D];

    for (genvar s = 0; s < D; s++) begin : g_stage
        logic         fire_in;
        logic [W-1:0] data_in;

        if (s == 0) begin : g_head
            assign fire_in = push_fire;
            assign data_in = push_data;
        end else begin : g_tail
            assign fire_in = fire_q[s-1];
            assign data_in = data_q[s-1];
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                fire_q[s] <= 1'b0;
                data_q[s] <= '0;
            end else if (flush) begin
                fire_q[s] <= 1'b0;
                data_q[s] <= '0;
            end else begin
                fire_q[s] <= fire_in;
                data_q[s] <= data_in;
            end
        end
    end

    assign fire = fire_q[D-1];
    assign data = data_q[D-1];

endmodule

// File: rtl/pe_lin_seq.sv
// pe_lin_seq: sequencer for the linear PE array.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : pe_lin_seq_if slave port
//     - accepts a job of k_len MAC steps (start_valid/start_ready), abort cancels it
//     - clears the array, streams operand beats with per-lane skew (lane i: i+1 stages)
//     - drains LANES+1 cycles, captures pe_outs into res, hands off via res_valid/res_ready
module pe_lin_seq #(
    parameter int unsigned LANES = systola_pkg::LANES,
    parameter int unsigned DW    = systola_pkg::DW,
    parameter int unsigned ACCW  = systola_pkg::ACCW,
    parameter int unsigned KW    = 8
) (
    input  logic       clk,
    input  logic       rstn,
    pe_lin_seq_if.slave bus
);

    import systola_pkg::*;

    localparam int unsigned CW = $clog2(LANES + 1);

    seq_state_t                 state_q, state_d;
    logic [KW-1:0]              remaining_q, remaining_d;
    logic [CW-1:0]              drain_q, drain_d;
    logic [LANES-1:0][ACCW-1:0] res_q;
    logic                       capture;
    logic                       beat;
    logic                       flush;

    assign beat  = bus.in_valid && (state_q == StStream);
    // Abort in IDLE has nothing to cancel.
    assign flush = bus.abort && (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        capture     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start_valid) begin
                    remaining_d = bus.k_len;
                    state_d     = StClear;
                end
            end
            StClear: begin
                drain_d = '0;
                state_d = (remaining_q != '0) ? StStream : StDrain;
            end
            StStream: begin
                if (beat) begin
                    remaining_d = remaining_q - KW'(1);
                    if (remaining_q == KW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // LANES+1 cycles: the last beat reaches lane LANES-1 after LANES
                // stages, and its accumulation is visible one cycle later.
                if (drain_q == CW'(LANES)) begin
                    capture = 1'b1;
                    state_d = StResult;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            StResult: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
            drain_d = '0;
            capture = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            drain_q     <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            if (capture) begin
                res_q <= bus.pe_outs;
            end
        end
    end

    // Bubbles carry zero operands so idle lanes present a quiet bus.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [2*DW-1:0] push_data;
        logic [2*DW-1:0] lane_data;

        assign push_data = beat ? {bus.in_w[i], bus.in_a[i]} : '0;

        skew_line #(
            .D(i + 1),
            .W(2 * DW)
        ) u_skew (
            .clk      (clk),
            .rstn     (rstn),
            .flush    (flush),
            .push_fire(beat),
            .push_data(push_data),
            .fire     (bus.pe_fire[i]),
            .data     (lane_data)
        );

        assign bus.pe_w[i] = lane_data[2*DW-1:DW];
        assign bus.pe_a[i] = lane_data[DW-1:0];
    end

    assign bus.start_ready = (state_q == StIdle);
    assign bus.in_ready    = (state_q == StStream);
    assign bus.pe_clr      = (state_q == StClear);
    assign bus.res_valid   = (state_q == StResult);
    assign bus.res         = res_q;

endmodule

// File: tb/tb_pe_lin_seq.sv
// tb_pe_lin_seq: self-checking bench for pe_lin_seq with a behavioural PE array
// model and a result scoreboard.
module tb_pe_lin_seq;

    import systola_pkg::*;

    localparam int unsigned KW = 8;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    pe_lin_seq_if #(.LANES(LANES), .DW(DW), .ACCW(ACCW), .KW(KW)) bus ();

    pe_lin_seq #(
        .LANES(LANES),
        .DW   (DW),
        .ACCW (ACCW),
        .KW   (KW)
    ) u_dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    // Behavioural PE array: clear, then acc += w*a per fired lane, wrapping at ACCW bits.
    res_vec_t acc;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (bus.pe_clr) begin
            acc <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.pe_fire[i]) begin
                    acc[i] <= acc[i] + ACCW'(32'(bus.pe_w[i]) * 32'(bus.pe_a[i]));
                end
            end
        end
    end
    assign bus.pe_outs = acc;

    typedef struct {
        int unsigned k;
        op_vec_t     w;
        op_vec_t     a;
        res_vec_t    exp;
    } vec_t;

    vec_t     tbl [5];
    res_vec_t exp_q [$];
    res_vec_t mon_exp;
    op_vec_t  sched_w [4];
    op_vec_t  sched_a [4];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard consumer: every result handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(bus.res_valid), 64'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 64'(bus.res), 64'(mon_exp));
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, ".start_ready"}, 64'(bus.start_ready), 64'(1));
        check({tag, ".in_ready"},    64'(bus.in_ready),    64'(0));
        check({tag, ".pe_clr"},      64'(bus.pe_clr),      64'(0));
        check({tag, ".pe_fire"},     64'(bus.pe_fire),     64'(0));
        check({tag, ".pe_w"},        64'(bus.pe_w),        64'(0));
        check({tag, ".pe_a"},        64'(bus.pe_a),        64'(0));
        check({tag, ".res_valid"},   64'(bus.res_valid),   64'(0));
        check({tag, ".res"},         64'(bus.res),         64'(0));
    endtask

    // Cycle-exact job: start offered in cycle 0 (DUT idle), beats in cycles flagged
    // in 'beats', operands taken in order from sched_w/sched_a.
    task automatic run_sched(input string tag, input int unsigned k, input logic [31:0] beats,
                             input int res_j, input bit hold, input res_vec_t exp);
        int               b;
        int               last_j;
        int               bidx;
        logic [LANES-1:0] fexp;
        b      = 0;
        last_j = 0;
        for (int m = 0; m < 32; m++) begin
            if (beats[m]) last_j = m;
        end
        exp_q.push_back(exp);
        bus.res_ready = !hold;
        for (int j = 0; j <= res_j; j++) begin
            @(posedge clk);
            #1;
            bus.start_valid = (j == 0);
            bus.k_len       = KW'(k);
            bus.in_valid    = beats[j];
            if (beats[j]) begin
                bus.in_w = sched_w[b];
                bus.in_a = sched_a[b];
                b++;
            end else begin
                bus.in_w = '0;
                bus.in_a = '0;
            end
            @(negedge clk);
            fexp = '0;
            for (int i = 0; i < LANES; i++) begin
                if (j >= 1 + i) fexp[i] = beats[j-1-i];
            end
            check({tag, ".pe_fire"},   64'(bus.pe_fire),   64'(fexp));
            check({tag, ".pe_clr"},    64'(bus.pe_clr),    64'(j == 1));
            check({tag, ".in_ready"},  64'(bus.in_ready),  64'((k != 0) && j >= 2 && j <= last_j));
            check({tag, ".res_valid"}, 64'(bus.res_valid), 64'(j == res_j));
            for (int i = 0; i < LANES; i++) begin
                if (fexp[i]) begin
                    bidx = 0;
                    for (int m = 0; m < j - 1 - i; m++) begin
                        if (beats[m]) bidx++;
                    end
                    check({tag, ".pe_w"}, 64'(bus.pe_w[i]), 64'(sched_w[bidx][i]));
                    check({tag, ".pe_a"}, 64'(bus.pe_a[i]), 64'(sched_a[bidx][i]));
                end
            end
        end
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.in_valid    = 1'b0;
    endtask

    // Loosely timed job: waits (bounded) for each handshake, beats back-to-back.
    task automatic run_job(input string tag, input vec_t v);
        bit ok;
        exp_q.push_back(v.exp);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b1;
        bus.k_len       = KW'(v.k);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.start_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, ".start_hs"}, 64'(ok), 64'(1));
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        for (int b = 0; b < int'(v.k); b++) begin
            bus.in_valid = 1'b1;
            bus.in_w     = v.w;
            bus.in_a     = v.a;
            ok = 1'b0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clk);
                if (bus.in_ready) ok = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!ok) begin
                check({tag, ".beat_hs"}, 64'(ok), 64'(1));
                break;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) ok = 1'b1;
        end
        check({tag, ".result_seen"}, 64'(ok), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{k: 1, w: {4{8'd2}}, a: {4{8'd3}}, exp: {4{12'd6}}};
        tbl[1] = '{k: 4, w: {8'd4, 8'd3, 8'd2, 8'd1}, a: {8'd8, 8'd7, 8'd6, 8'd5},
                   exp: {12'd128, 12'd84, 12'd48, 12'd20}};
        // 255 steps of 255*255 on lane 0: 255^3 mod 4096 = 767.
        tbl[2] = '{k: 255, w: {8'd0, 8'd0, 8'd0, 8'd255}, a: {8'd0, 8'd0, 8'd0, 8'd255},
                   exp: {12'd0, 12'd0, 12'd0, 12'd767}};
        tbl[3] = '{k: 2, w: {8'd255, 8'd0, 8'd17, 8'd200}, a: {8'd1, 8'd9, 8'd3, 8'd100},
                   exp: {12'd510, 12'd0, 12'd102, 12'd3136}};
        tbl[4] = '{k: 0, w: {4{8'd9}}, a: {4{8'd9}}, exp: '0};

        rstn            = 1'b0;
        bus.start_valid = 1'b0;
        bus.k_len       = '0;
        bus.abort       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_w        = '0;
        bus.in_a        = '0;
        bus.res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;

        // Single step with result held back for 10 cycles.
        sched_w[0] = {4{8'd2}};
        sched_a[0] = {4{8'd3}};
        run_sched("single", 1, 32'h0000_0004, 8, 1'b1, {4{12'd6}});
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("hold.res_valid",   64'(bus.res_valid),   64'(1));
            check("hold.res",         64'(bus.res),         64'({4{12'd6}}));
            check("hold.start_ready", 64'(bus.start_ready), 64'(0));
            @(posedge clk);
            #1;
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release.start_ready", 64'(bus.start_ready), 64'(1));
        check("release.res_valid",   64'(bus.res_valid),   64'(0));

        // k_len = 0: clear only, result 7 cycles after the start.
        run_sched("kzero", 0, 32'h0, 7, 1'b0, '0);

        // Gapped stream: beats in cycles 2, 5, 8; weights 1,2,3 per beat, a = lane+1.
        for (int b = 0; b < 3; b++) begin
            sched_w[b] = {4{8'(b + 1)}};
            sched_a[b] = {8'd4, 8'd3, 8'd2, 8'd1};
        end
        run_sched("gapped", 3, 32'h0000_0124, 14, 1'b0, {12'd24, 12'd18, 12'd12, 12'd6});

        for (int t = 0; t < 5; t++) begin
            run_job($sformatf("tbl%0d", t), tbl[t]);
        end

        // Abort in STREAM after 2 of 5 beats; the abort cycle also offers a beat.
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            bus.start_valid = (j == 0);
            bus.k_len       = KW'(5);
            bus.in_valid    = (j >= 2);
            bus.in_w        = {4{8'd1}};
            bus.in_a        = {4{8'd1}};
            bus.abort       = (j == 4);
        end
        @(negedge clk);
        check("abort.in_ready_before", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("abort.start_ready", 64'(bus.start_ready), 64'(1));
        check("abort.in_ready",    64'(bus.in_ready),    64'(0));
        check("abort.pe_fire",     64'(bus.pe_fire),     64'(0));
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("abort.res_valid", 64'(bus.res_valid), 64'(0));
            check("abort.fire_idle", 64'(bus.pe_fire),   64'(0));
        end
        run_job("after_abort", tbl[0]);

        // Reset asserted two cycles into DRAIN.
        @(posedge clk);
        #1;
        bus.start_valid = 1'b1;
        bus.k_len       = KW'(1);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_w     = {4{8'd5}};
        bus.in_a     = {4{8'd5}};
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_reset("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("post_reset.res_valid", 64'(bus.res_valid), 64'(0));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
